// File: rtl/cgufdsync_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cgufdsync_mc : multi-channel fractional clock-enable generator with   |
// | double-buffered dividers; CGUFDSYNC_MC_PHASE_EN adds phase preload.   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module cgufdsync_mc #(
  parameter int NCH    = 4,
  parameter int FDW    = 8,
  parameter int FD0RST = 0,
  parameter int FD2RST = (1 << FDW) - 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk0en,
  input  logic               clk1en,
  input  logic [NCH*FDW-1:0] fd0,
  input  logic [NCH*FDW-1:0] fd2,
  input  logic [NCH-1:0]     chain,
  input  logic               fdload,
`ifdef CGUFDSYNC_MC_PHASE_EN
  input  logic [NCH*FDW-1:0] phase,
`endif
  output logic               fdbusy,
  output logic [NCH-1:0]     clk2en,
  output logic [NCH-1:0]     clk2en_atclk1
);

  localparam logic [FDW-1:0] c_fd0_rst = FDW'(FD0RST);
  localparam logic [FDW-1:0] c_fd2_rst = FDW'(FD2RST);
  localparam logic [FDW:0]   c_acc_one = (FDW+1)'(1);

  logic [NCH*FDW-1:0] r_fd0_act, r_fd2_act, r_fd0_shd, r_fd2_shd;
  logic [NCH-1:0]     r_chain_act, r_chain_shd;
  logic               r_busy;
  logic               w_commit;

  assign w_commit = r_busy & clk0en & clk1en & ~fdload;
  assign fdbusy   = r_busy;

  // Bit 0 of chain is stored as 0 so channel 0 always follows the root enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fd0_act   <= {NCH{c_fd0_rst}};
      r_fd2_act   <= {NCH{c_fd2_rst}};
      r_chain_act <= '0;
      r_fd0_shd   <= {NCH{c_fd0_rst}};
      r_fd2_shd   <= {NCH{c_fd2_rst}};
      r_chain_shd <= '0;
      r_busy      <= 1'b0;
    end else if (clk0en) begin
      if (fdload) begin
        r_fd0_shd   <= fd0;
        r_fd2_shd   <= fd2;
        r_chain_shd <= chain & ~NCH'(1);
        r_busy      <= 1'b1;
      end else if (w_commit) begin
        r_fd0_act   <= r_fd0_shd;
        r_fd2_act   <= r_fd2_shd;
        r_chain_act <= r_chain_shd;
        r_busy      <= 1'b0;
      end
    end
  end

`ifdef CGUFDSYNC_MC_PHASE_EN
  logic [NCH*FDW-1:0] r_phase_shd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase_shd <= '0;
    end else if (clk0en && fdload) begin
      r_phase_shd <= phase;
    end
  end
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [FDW:0] r_c0, r_acc, w_fd0, w_fd2, w_preload;
    logic         r_atclk1, w_prev, w_par, w_rdy0, w_rdy2, w_fire, w_adv, w_en;

    if (i == 0) begin : g_root
      assign w_prev = 1'b0;
    end else begin : g_link
      assign w_prev = g_ch[i-1].w_en;
    end

    assign w_fd0  = {1'b0, r_fd0_act[i*FDW +: FDW]};
    assign w_fd2  = {1'b0, r_fd2_act[i*FDW +: FDW]};
    assign w_par  = r_chain_act[i] ? w_prev : clk1en;
    assign w_rdy0 = (r_c0 == w_fd0);
    assign w_rdy2 = r_acc[FDW];
    assign w_fire = clk0en & w_par & w_rdy0 & w_rdy2 & ~w_commit;
    // Gear steps only on parent enables, making the rate relative to the parent.
    assign w_adv  = w_par & (~w_rdy2 | w_fire);
    assign w_en   = r_atclk1 & w_par & clk0en & ~w_commit;

`ifdef CGUFDSYNC_MC_PHASE_EN
    assign w_preload = {1'b0, r_phase_shd[i*FDW +: FDW]};
`else
    assign w_preload = '0;
`endif

    always_ff @(posedge clk) begin
      if (reset) begin
        r_c0     <= '0;
        r_acc    <= '0;
        r_atclk1 <= 1'b0;
      end else if (clk0en) begin
        if (w_commit) begin
          r_c0     <= '0;
          r_acc    <= w_preload;
          r_atclk1 <= 1'b0;
        end else begin
          if (w_fire) begin
            r_c0 <= '0;
          end else if (!w_rdy0) begin
            r_c0 <= r_c0 + c_acc_one;
          end
          if (w_adv) begin
            r_acc <= {1'b0, r_acc[FDW-1:0]} + w_fd2 + c_acc_one;
          end
          if (w_fire) begin
            r_atclk1 <= 1'b1;
          end else if (w_par) begin
            r_atclk1 <= 1'b0;
          end
        end
      end
    end

    assign clk2en[i]        = w_en;
    assign clk2en_atclk1[i] = r_atclk1;
  end

endmodule
`default_nettype wire
